// File: rtl/ps2_command_decoder.sv
// rtl/ps2_command_decoder.sv - PS/2 scancode to hit/stand/deal command pulse decoder
//
// Purpose: decodes make, break (0xF0) and extended (0xE0) prefixed scancodes
// from the PS/2 byte receiver into one-cycle game command pulses. Per-key held
// flags suppress typematic auto-repeat so a held key pulses only once.
//
// Optional feature: define PS2_CMD_TIMEOUT_EN to abandon a dangling prefix
// (BRK/EXT/EXT_BRK) after TIMEOUT_CYCLES clocks without a received byte.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   rx_data[7:0]  in   received scancode byte, qualified by rx_valid
//   rx_valid      in   one-cycle strobe per received byte
//   rx_error      in   one-cycle strobe on parity/framing error
//   hit_pressed   out  one-cycle pulse on a new hit key press
//   stand_pressed out  one-cycle pulse on a new stand key press
//   deal_pressed  out  one-cycle pulse on a new deal key press
//   held[2:0]     out  {deal, stand, hit} currently-held flags
//   last_code[7:0] out last non-extended make code accepted
//   prefix_state[1:0] out current prefix FSM state, for debug

module ps2_command_decoder #(
  parameter logic [7:0]  KEY_HIT        = 8'h33,
  parameter logic [7:0]  KEY_STAND      = 8'h1B,
  parameter logic [7:0]  KEY_DEAL       = 8'h23,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic       hit_pressed,
  output logic       stand_pressed,
  output logic       deal_pressed,
  output logic [2:0] held,
  output logic [7:0] last_code,
  output logic [1:0] prefix_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] held_q, held_d;
  logic [2:0] pulse_q, pulse_d;
  logic [7:0] last_q, last_d;

  logic [2:0] key_match;
  logic       is_ignored;

  // One-hot in {deal, stand, hit} order so it lines up with held/pulse bits.
  assign key_match  = {rx_data == KEY_DEAL, rx_data == KEY_STAND, rx_data == KEY_HIT};
  // Keyboard housekeeping bytes (ack, BAT, echo, resend, overrun) are not keys.
  assign is_ignored = rx_data inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

`ifdef PS2_CMD_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    pulse_d = 3'b000;
    last_d  = last_q;
`ifdef PS2_CMD_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    // An errored frame discards its byte and abandons any pending prefix.
    if (rx_error) begin
      state_d = IDLE;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          if (rx_data == 8'hF0) begin
            state_d = BRK;
          end else if (rx_data == 8'hE0) begin
            state_d = EXT;
          end else if (!is_ignored) begin
            last_d  = rx_data;
            // Only keys not already held pulse; repeats just re-assert held.
            pulse_d = key_match & ~held_q;
            held_d  = held_q | key_match;
          end
        end
        BRK: begin
          // Any byte here, including 0xF0/0xE0, is the break code itself.
          held_d  = held_q & ~key_match;
          state_d = IDLE;
        end
        EXT:     state_d = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

`ifdef PS2_CMD_TIMEOUT_EN
    // A byte always takes priority over an expiring timeout on the same cycle.
    if (rx_valid || rx_error) begin
      cnt_d = '0;
    end else if (state_q != IDLE) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      held_q  <= 3'b000;
      pulse_q <= 3'b000;
      last_q  <= 8'h00;
`ifdef PS2_CMD_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
      last_q  <= last_d;
`ifdef PS2_CMD_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign hit_pressed   = pulse_q[0];
  assign stand_pressed = pulse_q[1];
  assign deal_pressed  = pulse_q[2];
  assign held          = held_q;
  assign last_code     = last_q;
  assign prefix_state  = state_q;

endmodule

// File: tb/tb_ps2_command_decoder.sv
// tb/tb_ps2_command_decoder.sv - scoreboard testbench for ps2_command_decoder

module tb_ps2_command_decoder;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_error = 1'b0;
  logic       hit_pressed, stand_pressed, deal_pressed;
  logic [2:0] held;
  logic [7:0] last_code;
  logic [1:0] prefix_state;

  ps2_command_decoder #(
    .KEY_HIT(8'h33), .KEY_STAND(8'h1B), .KEY_DEAL(8'h23), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_error(rx_error), .hit_pressed(hit_pressed), .stand_pressed(stand_pressed),
    .deal_pressed(deal_pressed), .held(held), .last_code(last_code),
    .prefix_state(prefix_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         stamp;
    logic [2:0] held;
    logic [7:0] last;
    logic [1:0] st;
  } st_t;
  typedef struct packed {
    int         stamp;
    logic [2:0] pulse;
  } pu_t;

  st_t sq[$];
  pu_t pq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: keyboard prefix mode (0 none, 1 break, 2 ext, 3 ext+break)
  logic [7:0] keys [3] = '{8'h33, 8'h1B, 8'h23};
  int         m_mode = 0;
  int         m_gap = 0;
  logic [2:0] m_held = 3'b000;
  logic [7:0] m_last = 8'h00;
  logic [2:0] m_pulse = 3'b000;

  task automatic model_reset();
    m_mode = 0; m_gap = 0; m_held = 3'b000; m_last = 8'h00; m_pulse = 3'b000;
  endtask

  task automatic model_step(input logic [7:0] b, input logic v, input logic e);
    m_pulse = 3'b000;
    if (e) begin
      m_mode = 0;
    end else if (v) begin
      if (m_mode == 0) begin
        if (b == 8'hF0) m_mode = 1;
        else if (b == 8'hE0) m_mode = 2;
        else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
          m_last = b;
          for (int k = 0; k < 3; k++)
            if (b == keys[k]) begin
              if (!m_held[k]) m_pulse[k] = 1'b1;
              m_held[k] = 1'b1;
            end
        end
      end else if (m_mode == 1) begin
        for (int k = 0; k < 3; k++) if (b == keys[k]) m_held[k] = 1'b0;
        m_mode = 0;
      end else if (m_mode == 2) begin
        m_mode = (b == 8'hF0) ? 3 : 0;
      end else begin
        m_mode = 0;
      end
    end
`ifdef PS2_CMD_TIMEOUT_EN
    if (v || e) m_gap = 0;
    else if (m_mode != 0) begin
      m_gap++;
      if (m_gap >= TO) begin m_mode = 0; m_gap = 0; end
    end
`endif
  endtask

  task automatic drive(input logic [7:0] b, input logic v, input logic e);
    @(posedge clk);
    #1;
    rx_data = b; rx_valid = v; rx_error = e;
    model_step(b, v, e);
    sq.push_back('{stamp: cyc + 1, held: m_held, last: m_last, st: 2'(m_mode)});
    if (m_pulse != 3'b000) pq.push_back('{stamp: cyc + 1, pulse: m_pulse});
  endtask

  task automatic send(input logic [7:0] b);
    drive(b, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: decoupled from the driver, matches by cycle stamp.
  st_t        me;
  pu_t        mp;
  logic [2:0] seen;
  always @(negedge clk) begin
    if (rst_n) begin
      while (sq.size() > 0 && sq[0].stamp <= cyc) begin
        me = sq.pop_front();
        chk("state_stamp", me.stamp, cyc);
        chk("held", {29'd0, held}, {29'd0, me.held});
        chk("last_code", {24'd0, last_code}, {24'd0, me.last});
        chk("prefix_state", {30'd0, prefix_state}, {30'd0, me.st});
      end
      seen = {deal_pressed, stand_pressed, hit_pressed};
      if (seen != 3'b000) begin
        if (pq.size() == 0) begin
          chk("unexpected_pulse", {29'd0, seen}, 32'd0);
        end else begin
          mp = pq.pop_front();
          chk("pulse_cycle", mp.stamp, cyc);
          chk("pulse_vec", {29'd0, seen}, {29'd0, mp.pulse});
        end
      end
      if (pq.size() > 0 && pq[0].stamp < cyc) begin
        mp = pq.pop_front();
        chk("missing_pulse", 32'd0, {29'd0, mp.pulse});
      end
    end
  end

  task automatic mid_reset();
    idle(1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_prefix_state", {30'd0, prefix_state}, 32'd0);
    chk("rst_held", {29'd0, held}, 32'd0);
    chk("rst_last_code", {24'd0, last_code}, 32'd0);
    chk("rst_pulses", {29'd0, deal_pressed, stand_pressed, hit_pressed}, 32'd0);
    model_reset();
    sq.delete();
    pq.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int r;
  logic [7:0] b;
  logic [7:0] ign [6] = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_prefix_state", {30'd0, prefix_state}, 32'd0);
    chk("reset_held", {29'd0, held}, 32'd0);
    chk("reset_last_code", {24'd0, last_code}, 32'd0);
    chk("reset_pulses", {29'd0, deal_pressed, stand_pressed, hit_pressed}, 32'd0);
    rst_n = 1'b1;

    // Single press and release
    send(8'h33); send(8'hF0); send(8'h33); idle(2);
    // Typematic stand, release, press again
    repeat (5) send(8'h1B);
    send(8'hF0); send(8'h1B); send(8'h1B); send(8'hF0); send(8'h1B); idle(2);
    // Extended make/break ignored, then a bare hit
    send(8'hE0); send(8'h33); send(8'hE0); send(8'hF0); send(8'h33);
    send(8'h33); send(8'hF0); send(8'h33); idle(1);
    // Independent keys
    send(8'h33); send(8'h23); send(8'hF0); send(8'h33); send(8'hF0); send(8'h23); idle(1);
    // Error during break, then a fresh press
    send(8'h33); send(8'hF0); drive(8'h33, 1'b1, 1'b1); idle(1);
    send(8'h33); send(8'hF0); send(8'h33);
    // 0xF0 / 0xE0 as break code bytes
    send(8'hF0); send(8'hF0); send(8'hF0); send(8'hE0); send(8'h23); send(8'hF0); send(8'h23);
    // Error with no prefix pending, and ignored housekeeping bytes
    drive(8'h1B, 1'b0, 1'b1); send(8'hFA); send(8'hAA); send(8'h00); idle(1);
    // Prefix timeout window
    send(8'hF0); idle(TO); send(8'h23); send(8'hF0); send(8'h23); idle(1);
    send(8'hE0); idle(TO + 3); send(8'h1B); send(8'hF0); send(8'h1B); idle(1);
    // Reset mid-sequence with a key held
    send(8'h33); send(8'hF0); mid_reset();
    send(8'h33); send(8'hF0); send(8'h33);

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: b = keys[r];
        3:       b = 8'hF0;
        4:       b = 8'hE0;
        5:       b = ign[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 19) == 0) drive(b, 1'($urandom_range(0, 1)), 1'b1);
      else send(b);
      r = $urandom_range(0, 9);
      if (r == 0) idle($urandom_range(TO - 2, TO + 2));
      else if (r < 4) idle($urandom_range(1, 3));
    end

    idle(4);
    repeat (3) @(negedge clk);
    #2;
    chk("pulse_queue_drained", pq.size(), 32'd0);
    chk("state_queue_drained", sq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
